// File: rtl/selector_dequeue_stage_pkg.sv
// Shared constants and helpers for the selector dequeue stage.
// The optional per-queue counters are enabled by defining DEQUEUE_STATS_EN.
package selector_dequeue_stage_pkg;

  // The output buffer always has exactly two entries.
  localparam int SDS_OUT_DEPTH     = 2;
  localparam int SDS_QUEUE_QTY_DEF = 4;
  localparam int SDS_DATA_BITS_DEF = 8;
  localparam int SDS_STAT_BITS_DEF = 16;

  // Width of the buffer occupancy count (0..SDS_OUT_DEPTH).
  localparam int SDS_OCC_BITS = $clog2(SDS_OUT_DEPTH + 1);

  // Width of a queue index. It is never narrower than one bit.
  function automatic int sds_idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selector_dequeue_stage_skid_buffer_2.sv
// Two-entry FIFO that holds dequeued words together with their source tag.
// The caller must never write while the buffer is full or read while it is empty.
module skid_buffer_2
  import selector_dequeue_stage_pkg::*;
#(
  parameter int DATA_BITS = SDS_DATA_BITS_DEF,
  parameter int SRC_BITS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATA_BITS-1:0]    wr_data,
  input  logic [SRC_BITS-1:0]     wr_src,
  input  logic                    rd,
  output logic [DATA_BITS-1:0]    rd_data,
  output logic [SRC_BITS-1:0]     rd_src,
  output logic [SDS_OCC_BITS-1:0] occ,
  output logic                    not_empty
);

  logic [DATA_BITS-1:0]    data_q [2];
  logic [DATA_BITS-1:0]    data_d [2];
  logic [SRC_BITS-1:0]     src_q  [2];
  logic [SRC_BITS-1:0]     src_d  [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [SDS_OCC_BITS-1:0] occ_q, occ_d;

  // Next state: write at the tail, advance the head on read, track the entry count.
  always_comb begin
    data_d   = data_q;
    src_d    = src_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr) begin
      data_d[wr_ptr_q] = wr_data;
      src_d[wr_ptr_q]  = wr_src;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (rd) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({wr, rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset also clears storage so the head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        src_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      data_q   <= data_d;
      src_q    <= src_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data   = data_q[rd_ptr_q];
  assign rd_src    = src_q[rd_ptr_q];
  assign occ       = occ_q;
  assign not_empty = (occ_q != '0);

endmodule

// File: rtl/selector_dequeue_stage.sv
// Dequeue stage behind the weighted round-robin arbiter: pops the selected queue
// FIFO, captures the word one cycle later and presents it on a valid/ready port.
// Define DEQUEUE_STATS_EN to add saturating per-queue pop counters on port stats.
module selector_dequeue_stage
  import selector_dequeue_stage_pkg::*;
#(
  parameter int QUEUE_QUANTITY = SDS_QUEUE_QTY_DEF,
  parameter int DATA_BITS      = SDS_DATA_BITS_DEF,
  parameter int OUT_DEPTH      = SDS_OUT_DEPTH,
  parameter int STAT_BITS      = SDS_STAT_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [sds_idx_bits(QUEUE_QUANTITY)-1:0] selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  input  logic                                ready_in,
  output logic                                valid_out,
  output logic [DATA_BITS-1:0]                data_out,
  output logic [sds_idx_bits(QUEUE_QUANTITY)-1:0] src_out
`ifdef DEQUEUE_STATS_EN
  ,
  output logic [QUEUE_QUANTITY*STAT_BITS-1:0] stats
`endif
);

  localparam int SEL_W = sds_idx_bits(QUEUE_QUANTITY);
  localparam logic [SDS_OCC_BITS:0] DEPTH_L = (SDS_OCC_BITS + 1)'(OUT_DEPTH);

  // The buffer is built for exactly two entries and a power-of-2 queue count.
  if (QUEUE_QUANTITY < 2 || (QUEUE_QUANTITY & (QUEUE_QUANTITY - 1)) != 0 ||
      OUT_DEPTH != SDS_OUT_DEPTH || STAT_BITS < 1) begin : g_bad_cfg
    $error("selector_dequeue_stage: unsupported parameter set");
  end

  logic [DATA_BITS-1:0]    words [QUEUE_QUANTITY];
  logic                    inflight_q, inflight_d;
  logic [SEL_W-1:0]        inflight_src_q, inflight_src_d;
  logic [SDS_OCC_BITS-1:0] occ;
  logic [SDS_OCC_BITS:0]   credit_used;
  logic                    xfer;

  for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_unpack
    assign words[gi] = buf_data[gi*DATA_BITS +: DATA_BITS];
  end

  // Buffered words plus the word in flight may never exceed the buffer depth;
  // a same-cycle transfer is deliberately not credited back.
  assign credit_used = {1'b0, occ} + {{SDS_OCC_BITS{1'b0}}, inflight_q};
  assign xfer        = valid_out & ready_in;

  // Pop decode: one-hot strobe toward the selected, non-empty queue when space is free.
  always_comb begin
    pop = '0;
    if (!rst && enb && selector_enb) begin
      if (!buf_empty[selector] && (credit_used < DEPTH_L)) begin
        pop[selector] = 1'b1;
      end
    end
  end

  // Fetch stage: remember that a read was issued and from which queue.
  always_comb begin
    inflight_d     = |pop;
    inflight_src_d = selector;
  end

  // In-flight registers; reset drops any word whose read is still outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= '0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
    end
  end

  // Capture stage: the FIFO read data arrives one cycle after the pop and is
  // always written, independent of enb, so no popped word is lost.
  skid_buffer_2 #(
    .DATA_BITS (DATA_BITS),
    .SRC_BITS  (SEL_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .wr        (inflight_q),
    .wr_data   (words[inflight_src_q]),
    .wr_src    (inflight_src_q),
    .rd        (xfer),
    .rd_data   (data_out),
    .rd_src    (src_out),
    .occ       (occ),
    .not_empty (valid_out)
  );

`ifdef DEQUEUE_STATS_EN
  for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_stats
    logic [STAT_BITS-1:0] cnt_q, cnt_d;

    // Count pops of this queue, holding at the maximum value.
    always_comb begin
      cnt_d = cnt_q;
      if (pop[gi] && (cnt_q != {STAT_BITS{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stats[gi*STAT_BITS +: STAT_BITS] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_selector_dequeue_stage.sv
// Self-checking bench for selector_dequeue_stage: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based reference model.
module tb_selector_dequeue_stage;

  localparam int QQ = 4;
  localparam int DB = 8;
  localparam int SW = 2;
`ifdef DEQUEUE_STATS_EN
  localparam int SB = 2;
`else
  localparam int SB = 16;
`endif

  logic              clk;
  logic              rst;
  logic              enb;
  logic [SW-1:0]     selector;
  logic              selector_enb;
  logic [QQ-1:0]     buf_empty;
  logic [QQ*DB-1:0]  buf_data;
  logic [QQ-1:0]     pop;
  logic              ready_in;
  logic              valid_out;
  logic [DB-1:0]     data_out;
  logic [SW-1:0]     src_out;
`ifdef DEQUEUE_STATS_EN
  logic [QQ*SB-1:0]  stats;
`endif

  selector_dequeue_stage #(
    .QUEUE_QUANTITY (QQ),
    .DATA_BITS      (DB),
    .OUT_DEPTH      (2),
    .STAT_BITS      (SB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .selector     (selector),
    .selector_enb (selector_enb),
    .buf_empty    (buf_empty),
    .buf_data     (buf_data),
    .pop          (pop),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .src_out      (src_out)
`ifdef DEQUEUE_STATS_EN
    ,
    .stats        (stats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words waiting for the sink, the word whose read is pending,
  // and per-queue pop counts.
  typedef struct packed {
    logic [SW-1:0] src;
    logic [DB-1:0] data;
  } item_t;

  item_t         mq[$];
  bit            m_pend;
  logic [SW-1:0] m_pend_src;
  bit            m_fresh;
  int            m_cnt [QQ];
  logic [QQ-1:0] m_last_pop;

  int errors;
  int checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // What pop must be now: a pop needs enable, a valid non-empty selection and a
  // free slot counting both buffered and pending words.
  function automatic logic [QQ-1:0] model_pop();
    logic [QQ-1:0] p;
    p = '0;
    if (!rst && enb && selector_enb && !buf_empty[selector] &&
        (mq.size() + (m_pend ? 1 : 0)) < 2)
      p[selector] = 1'b1;
    return p;
  endfunction

  // One clock: compare, then advance the model across the rising edge.
  task automatic step();
    logic [QQ-1:0] ep;
    bit            xfer;
    item_t         cap;
    #1;
    ep = model_pop();
    chk("pop", pop, ep);
    chk("valid_out", valid_out, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("data_out", data_out, mq[0].data);
      chk("src_out", src_out, mq[0].src);
    end else if (m_fresh) begin
      chk("data_out_rst", data_out, 0);
      chk("src_out_rst", src_out, 0);
    end
`ifdef DEQUEUE_STATS_EN
    for (int i = 0; i < QQ; i++)
      chk($sformatf("stats_q%0d", i), stats[i*SB +: SB], m_cnt[i]);
`endif
    xfer     = (mq.size() != 0) && ready_in;
    cap.src  = m_pend_src;
    cap.data = buf_data[m_pend_src*DB +: DB];
    m_last_pop = ep;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pend  = 0;
      m_fresh = 1;
      for (int i = 0; i < QQ; i++) m_cnt[i] = 0;
    end else begin
      if (xfer) void'(mq.pop_front());
      if (m_pend) begin
        mq.push_back(cap);
        m_fresh = 0;
      end
      m_pend     = |ep;
      m_pend_src = selector;
      for (int i = 0; i < QQ; i++)
        if (ep[i] && m_cnt[i] < (2**SB - 1)) m_cnt[i]++;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit r, input bit e, input bit se, input logic [SW-1:0] s,
                        input logic [QQ-1:0] emp, input bit rdy);
    rst = r; enb = e; selector_enb = se; selector = s; buf_empty = emp; ready_in = rdy;
  endtask

  int npops;

  initial begin
    errors = 0; checks = 0;
    m_pend = 0; m_pend_src = '0; m_fresh = 1; m_last_pop = '0;
    for (int i = 0; i < QQ; i++) m_cnt[i] = 0;
    buf_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    set_in(1, 1, 1, 2'd2, 4'b0000, 1);
    @(negedge clk);

    // Reset held with a live, non-empty selection: nothing pops, nothing is valid.
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_pop", pop, 0);
      chk("rst_valid", valid_out, 0);
      step();
    end

    // First pop and its N+2 appearance.
    set_in(0, 1, 1, 2'd2, 4'b0000, 1);
    #1 chk("first_pop", pop, 4'b0100);
    step();
    step();
    #1;
    chk("first_valid", valid_out, 1);
    chk("first_data", data_out, 8'hA5);
    chk("first_src", src_out, 2);
    for (int c = 0; c < 6; c++) step();

    // Sink stalled: exactly two pops, head held, then drain in order.
    set_in(0, 1, 0, 2'd0, 4'b0000, 1);
    for (int c = 0; c < 4; c++) step();
    set_in(0, 1, 1, 2'd1, 4'b0000, 0);
    npops = 0;
    for (int c = 0; c < 8; c++) begin
      buf_data = {$urandom, $urandom} & 32'hFFFFFFFF;
      step();
      if (m_last_pop != 0) npops++;
    end
    chk("stall_pops", npops, 2);
    ready_in = 1;
    for (int c = 0; c < 6; c++) begin
      buf_data = $urandom;
      step();
    end

    // Empty queue selected: never popped; buffer drains.
    set_in(0, 1, 1, 2'd1, 4'b0010, 1);
    for (int c = 0; c < 5; c++) begin
      #1 chk("empty_pop", pop, 0);
      step();
    end
    #1 chk("empty_valid", valid_out, 0);

    // enb drops right after a pop: the popped word still comes out.
    set_in(0, 1, 1, 2'd3, 4'b0000, 1);
    buf_data = {8'h7E, 8'h00, 8'h00, 8'h00};
    step();
    enb = 0;
    #1 chk("enb_low_pop", pop, 0);
    step();
    #1;
    chk("enb_low_valid", valid_out, 1);
    chk("enb_low_data", data_out, 8'h7E);
    chk("enb_low_src", src_out, 3);
    step();

    // Reset with one buffered and one pending word: all discarded.
    set_in(0, 1, 1, 2'd0, 4'b0000, 0);
    for (int c = 0; c < 2; c++) step();
    rst = 1;
    step();
    rst = 0; selector_enb = 0; ready_in = 1;
    #1 chk("post_rst_valid", valid_out, 0);
    step();
    selector_enb = 1; selector = 2'd0;
    buf_data = {8'h00, 8'h00, 8'h00, 8'h5C};
    step();
    selector_enb = 0;
    step();
    #1 chk("post_rst_data", data_out, 8'h5C);
    step();

`ifdef DEQUEUE_STATS_EN
    // Five pops of q0 then three of q3; 2-bit counters saturate at 3.
    set_in(1, 1, 0, 2'd0, 4'b0000, 1);
    step();
    rst = 0; selector_enb = 1;
    npops = 0;
    for (int c = 0; c < 40 && npops < 5; c++) begin
      step();
      if (m_last_pop != 0) npops++;
    end
    chk("stats_q0_pops", npops, 5);
    selector = 2'd3;
    npops = 0;
    for (int c = 0; c < 40 && npops < 3; c++) begin
      step();
      if (m_last_pop != 0) npops++;
    end
    chk("stats_q3_pops", npops, 3);
    selector_enb = 0;
    step();
    #1;
    chk("stats_q0_sat", stats[0*SB +: SB], 3);
    chk("stats_q1_zero", stats[1*SB +: SB], 0);
    chk("stats_q3", stats[3*SB +: SB], 3);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      enb          = ($urandom_range(0, 9) != 0);
      selector_enb = ($urandom_range(0, 9) < 8);
      selector     = SW'($urandom_range(0, QQ - 1));
      buf_empty    = QQ'($urandom & $urandom);
      ready_in     = ($urandom_range(0, 9) < 7);
      buf_data     = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
